fiat_25519_carry_square_sdiv_32s_6ns_32_seq: RTL and testbench

- Sequential signed-by-unsigned divider for the fiat_25519_carry_square datapath.
- Inverse operation of the combinational 32s x 6ns multiplier: a signed 32-bit dividend divided by an unsigned 6-bit divisor gives a 32-bit quotient and a remainder.
- Restoring algorithm, one quotient bit per clock.
- Uses the ap_start/ap_done/ap_idle/ap_ready block handshake, so the scheduler can share one divider across several reduction steps.

---
 rtl/fiat_25519_div_pkg.sv | 10 +
 rtl/fiat_25519_div_step.sv | 22 ++
 rtl/fiat_25519_carry_square_sdiv_32s_6ns_32_seq.sv | 106 ++++++++++
 tb/tb_fiat_25519_carry_square_sdiv_32s_6ns_32_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fiat_25519_div_pkg.sv
// Shared types and constants for the fiat_25519 sequential signed divider.
package fiat_25519_div_pkg;
  localparam int DIN0_W = 32;
  localparam int DIV_LAT = DIN0_W + 3;
  localparam int CNT_W = $clog2(DIN0_W);
  localparam logic [31:0] SAT_POS = 32'h7FFFFFFF;
  localparam logic [31:0] SAT_NEG = 32'h80000000;

  typedef enum logic [2:0] {IDLE, INIT, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/fiat_25519_div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder
// and subtract the divisor when it fits.
module fiat_25519_div_step #(
  parameter int W = 6
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);
  logic [W+1:0] sh;
  logic [W+1:0] dv;
  logic [W+1:0] diff;

  assign sh      = {rem_in, bit_in};
  assign dv      = {2'b00, divisor};
  assign diff    = sh - dv;
  assign q_bit   = (sh >= dv);
  // Remainder before the shift is below the divisor, so W+1 bits always suffice.
  assign rem_out = q_bit ? diff[W:0] : sh[W:0];
endmodule

// File: rtl/fiat_25519_carry_square_sdiv_32s_6ns_32_seq.sv
// Sequential restoring divider, signed dividend by unsigned divisor, ap_* handshake.
// Optional clock-enable port ap_ce when FIAT_25519_SDIV_CE_EN is defined.
module fiat_25519_carry_square_sdiv_32s_6ns_32_seq
  import fiat_25519_div_pkg::*;
#(
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
`ifdef FIAT_25519_SDIV_CE_EN
  input  logic                  ap_ce,
`endif
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din0_WIDTH-1:0] rem,
  output logic                  div_by_zero
);
  localparam int CW = $clog2(din0_WIDTH);
  localparam int RW = din1_WIDTH + 1;

  state_t                state;
  logic [din0_WIDTH-1:0] a_r, mag, rem_ext;
  logic [din1_WIDTH-1:0] b_r;
  logic [RW-1:0]         prem, prem_nx;
  logic [CW-1:0]         cnt;
  logic                  q_bit, sign_q, dbz_r, ce;

`ifdef FIAT_25519_SDIV_CE_EN
  assign ce = ap_ce;
`else
  assign ce = 1'b1;
`endif

  fiat_25519_div_step #(.W(din1_WIDTH)) u_step (
    .rem_in (prem),
    .bit_in (mag[din0_WIDTH-1]),
    .divisor(b_r),
    .rem_out(prem_nx),
    .q_bit  (q_bit)
  );

  assign rem_ext  = din0_WIDTH'(prem);
  assign ap_idle  = (state == IDLE);
  assign ap_ready = ap_idle & ap_start & ce;
  assign ap_done  = (state == DONE) & ce;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= IDLE;
      dout        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      mag         <= '0;
      prem        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      dbz_r       <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: if (ap_start) begin
          a_r   <= din0;
          b_r   <= din1;
          state <= INIT;
        end
        INIT: begin
          // Magnitude is held unsigned so the most negative dividend needs no extra bit.
          sign_q <= a_r[din0_WIDTH-1];
          mag    <= a_r[din0_WIDTH-1] ? -a_r : a_r;
          prem   <= '0;
          cnt    <= CW'(din0_WIDTH - 1);
          dbz_r  <= (b_r == '0);
          state  <= ITER;
        end
        ITER: begin
          // Quotient bits fill the magnitude register from the bottom as it drains.
          prem <= prem_nx;
          mag  <= {mag[din0_WIDTH-2:0], q_bit};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (dbz_r) begin
            dout <= sign_q ? dout_WIDTH'(SAT_NEG) : dout_WIDTH'(SAT_POS);
            rem  <= a_r;
          end else begin
            dout <= sign_q ? -mag : mag;
            rem  <= sign_q ? -rem_ext : rem_ext;
          end
          div_by_zero <= dbz_r;
          state       <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fiat_25519_carry_square_sdiv_32s_6ns_32_seq.sv
// Directed bench for the sequential signed divider: results, latency, handshake, reset abort.
module tb_fiat_25519_carry_square_sdiv_32s_6ns_32_seq;
  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_ready, ap_done, div_by_zero;
  logic [31:0] din0 = '0;
  logic [5:0]  din1 = '0;
  logic [31:0] dout, rem;
  int          vectors = 0;
  int          miscompares = 0;
`ifdef FIAT_25519_SDIV_CE_EN
  logic        ap_ce = 1'b1;
  int          ce_at = -1;
`endif

  always #5 ap_clk = ~ap_clk;

  fiat_25519_carry_square_sdiv_32s_6ns_32_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
`ifdef FIAT_25519_SDIV_CE_EN
    .ap_ce(ap_ce),
`endif
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .din0(din0), .din1(din1), .dout(dout), .rem(rem), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; counts edges (accept edge = 1) until ap_done.
  task automatic wait_done(input string tag, input int lat);
    int cnt = 1;
    while (cnt < 200) begin
      @(negedge ap_clk);
      ap_start = 1'b0;
`ifdef FIAT_25519_SDIV_CE_EN
      ap_ce = !(ce_at >= 0 && cnt >= ce_at && cnt < ce_at + 5);
`endif
      #1;
      if (ap_done) break;
      @(posedge ap_clk);
      cnt++;
    end
    chk({tag, ".lat"}, 32'(cnt), 32'(lat));
  endtask

  task automatic results(input string tag, input logic [31:0] eq, input logic [31:0] er, input logic ez);
    chk({tag, ".dout"}, dout, eq);
    chk({tag, ".rem"}, rem, er);
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(ez));
    @(negedge ap_clk);
    #1;
    chk({tag, ".done_pulse"}, 32'(ap_done), 32'd0);
    chk({tag, ".idle_after"}, 32'(ap_idle), 32'd1);
  endtask

  task automatic run(input logic [31:0] a, input logic [5:0] b, input logic [31:0] eq,
                     input logic [31:0] er, input logic ez, input int lat, input string tag);
    @(negedge ap_clk);
    din0 = a; din1 = b; ap_start = 1'b1;
    #1;
    chk({tag, ".ready"}, 32'(ap_ready), 32'd1);
    @(posedge ap_clk);
    wait_done(tag, lat);
    results(tag, eq, er, ez);
  endtask

  initial begin
    int rdy_n = 0;
    int seen = 0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    #1;
    chk("rst.idle", 32'(ap_idle), 32'd1);
    chk("rst.ready", 32'(ap_ready), 32'd0);
    chk("rst.done", 32'(ap_done), 32'd0);
    chk("rst.dout", dout, 32'd0);
    chk("rst.rem", rem, 32'd0);
    chk("rst.dbz", 32'(div_by_zero), 32'd0);
    ap_rst = 1'b0;

    run(32'd100,        6'd7,  32'd14,        32'd2,         1'b0, 35, "p100_7");
    run(32'hFFFFFF9C,   6'd7,  32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 35, "n100_7");
    run(32'h80000000,   6'd1,  32'h80000000,  32'd0,         1'b0, 35, "min_1");
    run(32'h7FFFFFFF,   6'd63, 32'd34087042,  32'd1,         1'b0, 35, "max_63");
    run(32'd5,          6'd0,  32'h7FFFFFFF,  32'd5,         1'b1, 35, "p5_0");
    run(32'hFFFFFFFB,   6'd0,  32'h80000000,  32'hFFFFFFFB,  1'b1, 35, "n5_0");

    // ap_start held high; operands change every cycle except at the next IDLE.
    @(negedge ap_clk);
    din0 = 32'd200; din1 = 6'd7; ap_start = 1'b1;
    #1;
    chk("b2b.ready0", 32'(ap_ready), 32'd1);
    @(posedge ap_clk);
    for (int n = 1; n <= 36; n++) begin
      @(negedge ap_clk);
      din0 = (n == 36) ? 32'd50 : 32'(9999 + n);
      din1 = (n == 36) ? 6'd6 : 6'd1;
      #1;
      if (ap_ready) rdy_n++;
      if (n == 35) begin
        chk("b2b.done1", 32'(ap_done), 32'd1);
        chk("b2b.dout1", dout, 32'd28);
        chk("b2b.rem1", rem, 32'd4);
      end
      if (n == 36) chk("b2b.ready36", 32'(ap_ready), 32'd1);
      @(posedge ap_clk);
    end
    chk("b2b.ready_cnt", 32'(rdy_n), 32'd1);
    wait_done("b2b2", 35);
    results("b2b2", 32'd8, 32'd2, 1'b0);

    // Abort in the middle of the iteration loop.
    @(negedge ap_clk);
    din0 = 32'd1000; din1 = 6'd3; ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    chk("abort.idle", 32'(ap_idle), 32'd1);
    chk("abort.done", 32'(ap_done), 32'd0);
    chk("abort.dout", dout, 32'd0);
    chk("abort.rem", rem, 32'd0);
    chk("abort.dbz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge ap_clk);
      #1;
      if (ap_done) seen++;
    end
    chk("abort.no_done", 32'(seen), 32'd0);
    run(32'd1000, 6'd3, 32'd333, 32'd1, 1'b0, 35, "after_abort");

`ifdef FIAT_25519_SDIV_CE_EN
    ce_at = 10;
    run(32'd100, 6'd7, 32'd14, 32'd2, 1'b0, 40, "ce_stall");
    ce_at = -1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
